pc_flag_control: RTL

Program-counter and condition-flag stage directly downstream of the ALU in the single-cycle 16-bit CPU. It captures the ALU's `Flag` output `[N:V:Z]` into an architectural flag register, using per-opcode write enables. It evaluates branch conditions for B/BR against the committed flags and sequences the PC. HLT moves the block into a terminal halted state.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/branch_cond.sv | 34 +++
 rtl/pc_flag_control.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, branch condition, flag index and state definitions
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        COND_NEQ    = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GTE    = 3'b100,
        COND_LTE    = 3'b101,
        COND_OVFL   = 3'b110,
        COND_UNCOND = 3'b111
    } cond_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Which [N:V:Z] bits an opcode is allowed to write; others are stale on the ALU side.
    function automatic logic [2:0] flag_wr_mask(input logic [3:0] op);
        logic [2:0] mask;
        mask = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                  mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR:  mask[FLAG_Z] = 1'b1;
            default:                         mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - evaluates a B/BR condition code against committed flags
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic n;
    logic v;
    logic z;

    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];
    assign z = flags[FLAG_Z];

    // Decode the condition field into a single taken bit.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEQ:    taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GTE:    taken = z | (~z & ~n);
            COND_LTE:    taken = n | z;
            COND_OVFL:   taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_control.sv
// rtl/pc_flag_control.sv - flag register, branch resolution and PC sequencing after the ALU
module pc_flag_control
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [2:0]  cond,
    input  logic [8:0]  imm9,
    input  logic [15:0] reg_target,
    input  logic [2:0]  alu_flag,
    input  logic        stall,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [2:0]  flag_q,
    output logic        branch_taken,
    output logic        halted
);

    state_e      state_q;
    state_e      state_d;
    logic        run;
    logic        advance;
    logic        cond_true;
    logic [2:0]  wr_mask;
    logic [15:0] b_target;
    logic [15:0] pc_d;

    branch_cond u_branch_cond (
        .cond  (cond),
        .flags (flag_q),
        .taken (cond_true)
    );

    assign pc_plus2 = pc + 16'd2;
    // imm9 counts instructions; shift left once to get a byte offset.
    assign b_target = pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};

    // State register: only reset leaves HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an unstalled HLT in RUN enters HALT.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && !stall && opcode == OP_HLT) begin
            state_d = ST_HALT;
        end
    end

    // Outputs and qualifiers derived from the current state.
    always_comb begin
        run          = (state_q == ST_RUN);
        halted       = (state_q == ST_HALT);
        advance      = run & ~stall;
        branch_taken = run & cond_true & (opcode == OP_B || opcode == OP_BR);
        wr_mask      = advance ? flag_wr_mask(opcode) : 3'b000;
    end

    // Next-PC selection; HALT, stall and HLT all freeze the PC.
    always_comb begin
        pc_d = pc_plus2;
        if (!advance || opcode == OP_HLT) begin
            pc_d = pc;
        end else if (branch_taken && opcode == OP_B) begin
            pc_d = b_target;
        end else if (branch_taken && opcode == OP_BR) begin
            pc_d = reg_target;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

    // Flag register with per-bit enables; unenabled ALU bits are never sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 3'b000;
        end else begin
            flag_q <= (flag_q & ~wr_mask) | (alu_flag & wr_mask);
        end
    end

endmodule
